// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: selector codes, instruction kinds,
// flag bit positions, FSM states and the latched-instruction record.
package alu_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int FLAG_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_READ = 2'b10,
    KIND_RSVD = 2'b11
  } kind_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    kind_e             kind;
    logic [2:0]        op;
    logic              dst;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } instr_t;

  function automatic logic [DATA_W-1:0] sel_reg(input logic dst,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return dst ? b : a;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequential front end for the combinational ALU: accepts one instruction per
// handshake, runs it through the ALU, writes back A/B/flags and returns a response.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_dst,
  input  logic             cmd_imm_en,
  input  logic [W-1:0]     cmd_imm,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_s,
  input  logic [W-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] retired
);

  state_e         state;
  state_e         state_nxt;
  instr_t         ins;
  logic [W-1:0]   reg_a;
  logic [W-1:0]   reg_b;
  logic [3:0]     flags;
  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic [2:0]     alu_s_q;

  logic [W-1:0]   wb_a;
  logic [W-1:0]   wb_b;
  logic [3:0]     wb_flags;
  logic [W-1:0]   wb_data;
  logic           wb_err;

  logic           cmd_fire;
  logic           rsp_fire;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (cmd_fire) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU operands come from the latched instruction only while in EXEC and
  // otherwise hold whatever was last presented.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_s     = alu_s_q;
    if (state == ST_EXEC) begin
      alu_a = sel_reg(ins.dst, reg_a, reg_b);
      alu_b = ins.imm_en ? ins.imm : reg_b;
      alu_s = ins.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins <= '0;
    end else if (cmd_fire) begin
      ins.kind   <= kind_e'(cmd_kind);
      ins.op     <= cmd_op;
      ins.dst    <= cmd_dst;
      ins.imm_en <= cmd_imm_en;
      ins.imm    <= cmd_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_s_q <= '0;
    end else if (state == ST_EXEC) begin
      alu_a_q <= alu_a;
      alu_b_q <= alu_b;
      alu_s_q <= alu_s;
    end
  end

  always_comb begin
    wb_a     = reg_a;
    wb_b     = reg_b;
    wb_flags = flags;
    wb_data  = '0;
    wb_err   = 1'b0;
    unique case (ins.kind)
      KIND_ALU: begin
        if (ins.dst) wb_b = alu_result;
        else         wb_a = alu_result;
        wb_flags = alu_flags;
        wb_data  = alu_result;
      end
      KIND_LOAD: begin
        if (ins.dst) wb_b = ins.imm;
        else         wb_a = ins.imm;
        wb_data = ins.imm;
      end
      KIND_READ: begin
        wb_data = sel_reg(ins.dst, reg_a, reg_b);
      end
      default: begin
        wb_err = 1'b1;
      end
    endcase
  end

  // Write-back and response capture happen together on the EXEC edge, so
  // rsp_flags always reflects the flags register after the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a     <= '0;
      reg_b     <= '0;
      flags     <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_EXEC) begin
      reg_a     <= wb_a;
      reg_b     <= wb_b;
      flags     <= wb_flags;
      rsp_data  <= wb_data;
      rsp_flags <= wb_flags;
      rsp_err   <= wb_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (rsp_fire) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU in the loop, directed scenarios,
// random instructions against an architectural register/flags model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [2:0]  cmd_op;
  logic        cmd_dst;
  logic        cmd_imm_en;
  logic [7:0]  cmd_imm;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_s;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] retired;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ma;
  logic [7:0]  mb;
  logic [3:0]  mf;
  logic [15:0] mret;

  always #5 clk = ~clk;

  alu_sequencer #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .retired(retired)
  );

  // ALU behaviour in plain integer arithmetic; returns {result, z, n, c, v}.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
    int ua, ub, sa, sb, r, sr;
    logic [7:0] res;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 0; sr = 0;
    case (s)
      3'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = 255 - ua;
      3'd5: r = ua ^ ub;
      3'd6: r = ua * 2;
      default: r = ua / 2;
    endcase
    res = r[7:0];
    return {res, (res == 8'd0), res[7], c, v};
  endfunction

  always_comb {alu_result, alu_flags} = alu_fn(alu_a, alu_b, alu_s);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] k, input logic [2:0] op, input logic d,
                         input logic ie, input logic [7:0] imm, input int stall,
                         input bit poke, output logic [7:0] od,
                         output logic [3:0] of, output logic oe);
    logic [7:0]  ea, eb, ed;
    logic [3:0]  ef;
    logic        ee;
    logic [11:0] r;
    ea = d ? mb : ma;
    eb = ie ? imm : mb;
    ee = 1'b0;
    ed = 8'd0;
    case (k)
      2'd0: begin
        r = alu_fn(ea, eb, op);
        ed = r[11:4];
        mf = r[3:0];
        if (d) mb = ed; else ma = ed;
      end
      2'd1: begin
        ed = imm;
        if (d) mb = imm; else ma = imm;
      end
      2'd2: ed = d ? mb : ma;
      default: ee = 1'b1;
    endcase
    ef = mf;

    @(negedge clk);
    cmd_kind = k; cmd_op = op; cmd_dst = d; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu_a", 32'(alu_a), 32'(ea));
    chk("exec_alu_b", 32'(alu_b), 32'(eb));
    chk("exec_alu_s", 32'(alu_s), 32'(op));
    @(posedge clk); #1;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_data", 32'(rsp_data), 32'(ed));
    chk("resp_flags", 32'(rsp_flags), 32'(ef));
    chk("resp_err", 32'(rsp_err), 32'(ee));
    chk("resp_retired", 32'(retired), 32'(mret));
    od = rsp_data; of = rsp_flags; oe = rsp_err;
    if (stall > 0) begin
      rsp_ready = 1'b0;
      if (poke) begin
        cmd_kind = 2'd1; cmd_dst = 1'b0; cmd_imm_en = 1'b0; cmd_imm = 8'hEE;
        cmd_valid = 1'b1;
      end
      repeat (stall) begin
        @(posedge clk); #1;
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("stall_data", 32'(rsp_data), 32'(ed));
        chk("stall_flags", 32'(rsp_flags), 32'(ef));
        chk("stall_err", 32'(rsp_err), 32'(ee));
        chk("stall_retired", 32'(retired), 32'(mret));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    mret = mret + 16'd1;
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_retired", 32'(retired), 32'(mret));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_s"}, 32'(alu_s), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] od;
    logic [3:0] of;
    logic       oe;
    logic [1:0] rk;
    logic [2:0] rop;
    logic       rd, rie;
    logic [7:0] rimm;

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_kind = '0; cmd_op = '0; cmd_dst = 1'b0; cmd_imm_en = 1'b0; cmd_imm = '0;
    ma = '0; mb = '0; mf = '0; mret = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reads straight after reset
    run_cmd(2'd2, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("read_a_rst", 32'({od, of, oe}), 32'h0);
    run_cmd(2'd2, 3'd0, 1'b1, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("read_b_rst", 32'({od, of, oe}), 32'h0);
    chk("retired_two", 32'(retired), 32'd2);

    // ADD overflow, then reserved kind leaves state untouched
    run_cmd(2'd1, 3'd0, 1'b0, 1'b0, 8'h7F, 0, 1'b0, od, of, oe);
    run_cmd(2'd1, 3'd0, 1'b1, 1'b0, 8'h01, 0, 1'b0, od, of, oe);
    run_cmd(2'd0, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("add_data", 32'(od), 32'h80);
    chk("add_flags", 32'(of), 32'h5);
    run_cmd(2'd2, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("add_read_a", 32'(od), 32'h80);
    run_cmd(2'd3, 3'd2, 1'b0, 1'b1, 8'h33, 0, 1'b0, od, of, oe);
    chk("rsvd_err", 32'(oe), 32'd1);
    chk("rsvd_data", 32'(od), 32'h00);
    chk("rsvd_flags", 32'(of), 32'h5);
    run_cmd(2'd2, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("rsvd_read_a", 32'(od), 32'h80);
    run_cmd(2'd2, 3'd0, 1'b1, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("rsvd_read_b", 32'(od), 32'h01);

    // SUB with immediate: borrow and zero cases
    run_cmd(2'd1, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    run_cmd(2'd0, 3'd1, 1'b0, 1'b1, 8'h01, 0, 1'b0, od, of, oe);
    chk("sub_borrow_data", 32'(od), 32'hFF);
    chk("sub_borrow_flags", 32'(of), 32'h4);
    run_cmd(2'd1, 3'd0, 1'b0, 1'b0, 8'h05, 0, 1'b0, od, of, oe);
    run_cmd(2'd0, 3'd1, 1'b0, 1'b1, 8'h05, 0, 1'b0, od, of, oe);
    chk("sub_zero_data", 32'(od), 32'h00);
    chk("sub_zero_flags", 32'(of), 32'hA);

    // Shift out the top bit, then invert
    run_cmd(2'd1, 3'd0, 1'b0, 1'b0, 8'h81, 0, 1'b0, od, of, oe);
    run_cmd(2'd0, 3'd6, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("shl_data", 32'(od), 32'h02);
    chk("shl_flags", 32'(of), 32'h0);
    run_cmd(2'd0, 3'd4, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("not_data", 32'(od), 32'hFD);
    chk("not_flags", 32'(of), 32'h4);

    // Backpressure with a pending instruction that must not be taken
    run_cmd(2'd1, 3'd0, 1'b1, 1'b0, 8'h3C, 5, 1'b1, od, of, oe);
    run_cmd(2'd2, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("bp_read_a", 32'(od), 32'hFD);
    run_cmd(2'd0, 3'd0, 1'b1, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("b_plus_b", 32'(od), 32'h78);

    // Random instructions against the model
    for (int i = 0; i < 40; i++) begin
      rk = 2'($urandom_range(0, 3));
      rop = 3'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      rie = 1'($urandom_range(0, 1));
      rimm = 8'($urandom_range(0, 255));
      run_cmd(rk, rop, rd, rie, rimm, int'($urandom_range(0, 2)), 1'b0, od, of, oe);
    end

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    cmd_kind = 2'd1; cmd_op = 3'd3; cmd_dst = 1'b0; cmd_imm_en = 1'b1; cmd_imm = 8'h55;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_in_exec", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    ma = '0; mb = '0; mf = '0; mret = '0;
    run_cmd(2'd2, 3'd0, 1'b0, 1'b0, 8'h00, 0, 1'b0, od, of, oe);
    chk("abort_read_a", 32'(od), 32'h00);
    chk("abort_retired", 32'(retired), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
